// File: rtl/xgcd_job_ctrl.sv
// APB-programmed job controller for a single XGCD engine: operand staging,
// start/done handshake, cycle measurement, timeout abort and sticky status/IRQ.
module xgcd_job_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [11:0]      PADDR,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  output logic             ENG_START,
  output logic [WIDTH-1:0] ENG_A,
  output logic [WIDTH-1:0] ENG_B,
  input  logic             ENG_DONE,
  input  logic [WIDTH-1:0] ENG_RESULT,
  output logic             IRQ,
  output logic             START_OUT,
  output logic             DONE_OUT
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_FINISH
  } state_t;

  localparam logic [31:0] ID_VALUE = 32'h5A5A_5A5A;

  state_t           state_q, state_d;
  logic             busy;
  logic             irqEn_q;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             irq_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [WIDTH-1:0] engA_q, engB_q;
  logic [WIDTH-1:0] result_q;
  logic [31:0]      cycles_q;
  logic [31:0]      cycInc;
  logic [31:0]      tlimit_q;
  logic [31:0]      prdata_q;
  logic [31:0]      rdata;

  logic [9:0]       offset;
  logic             accessWr;
  logic             setupRd;
  logic             mapped;
  logic             ctrlWr, statusWr, opaWr, opbWr, tlimitWr;
  logic             goReq, abortReq, goErr, opErr;
  logic             timeoutHit;
  logic             setDone, setTimeout;
  logic             unusedAddr;

  assign offset     = PADDR[11:2];
  assign unusedAddr = ^PADDR[1:0];
  assign accessWr   = PSEL & PENABLE & PWRITE;
  assign setupRd    = PSEL & ~PENABLE & ~PWRITE;
  assign mapped     = (offset < 10'd8);

  assign ctrlWr   = accessWr & (offset == 10'd1);
  assign statusWr = accessWr & (offset == 10'd2);
  assign opaWr    = accessWr & (offset == 10'd3);
  assign opbWr    = accessWr & (offset == 10'd4);
  assign tlimitWr = accessWr & (offset == 10'd7);

  // ABORT outranks GO when both are written during a job.
  assign abortReq = ctrlWr & PWDATA[2] & busy;
  assign goReq    = ctrlWr & PWDATA[0] & ~busy;
  assign goErr    = ctrlWr & PWDATA[0] & ~PWDATA[2] & busy;
  assign opErr    = (opaWr | opbWr) & busy;

  assign PSLVERR = PSEL & PENABLE & (~mapped | goErr | opErr);
  assign PREADY  = 1'b1;

  assign cycInc     = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
  assign timeoutHit = (tlimit_q != 32'd0) & (cycInc == tlimit_q);

  assign setDone    = (state_q == ST_FINISH) & ~abortReq;
  assign setTimeout = (state_q == ST_WAIT) & ~ENG_DONE & timeoutHit & ~abortReq;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (goReq) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ENG_DONE) begin
          state_d = ST_FINISH;
        end else if (timeoutHit) begin
          state_d = ST_IDLE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abortReq) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    ENG_START = (state_q == ST_LAUNCH);
    DONE_OUT  = (state_q == ST_FINISH);
  end

  assign START_OUT = ENG_START;

  // A hardware set in the same cycle as a W1C leaves the bit set.
  assign done_d    = (done_q & ~(statusWr & PWDATA[1])) | setDone;
  assign timeout_d = (timeout_q & ~(statusWr & PWDATA[2])) | setTimeout;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      irqEn_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      irq_q     <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      tlimit_q  <= 32'd0;
    end else begin
      done_q    <= done_d;
      timeout_q <= timeout_d;
      irq_q     <= irqEn_q & (done_q | timeout_q);
      if (ctrlWr) begin
        irqEn_q <= PWDATA[1];
      end
      if (opaWr && !busy) begin
        opa_q <= PWDATA[WIDTH-1:0];
      end
      if (opbWr && !busy) begin
        opb_q <= PWDATA[WIDTH-1:0];
      end
      if (tlimitWr) begin
        tlimit_q <= PWDATA;
      end
    end
  end

  // Job datapath: operands are frozen at GO so the engine sees stable inputs.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      engA_q   <= '0;
      engB_q   <= '0;
      cycles_q <= 32'd0;
      result_q <= '0;
    end else begin
      if (goReq) begin
        engA_q   <= opa_q;
        engB_q   <= opb_q;
        cycles_q <= 32'd0;
      end else if (state_q == ST_WAIT) begin
        cycles_q <= cycInc;
      end
      if ((state_q == ST_WAIT) && ENG_DONE && !abortReq) begin
        result_q <= ENG_RESULT;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (offset)
      10'd0:   rdata = ID_VALUE;
      10'd1:   rdata = {29'd0, 1'b0, irqEn_q, 1'b0};
      10'd2:   rdata = {29'd0, timeout_q, done_q, busy};
      10'd3:   rdata = 32'(opa_q);
      10'd4:   rdata = 32'(opb_q);
      10'd5:   rdata = 32'(result_q);
      10'd6:   rdata = cycles_q;
      10'd7:   rdata = tlimit_q;
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      prdata_q <= 32'd0;
    end else if (setupRd) begin
      prdata_q <= rdata;
    end
  end

  assign PRDATA = prdata_q;
  assign ENG_A  = engA_q;
  assign ENG_B  = engB_q;
  assign IRQ    = irq_q;

endmodule

// File: tb/tb_xgcd_job_ctrl.sv
// Directed bench for xgcd_job_ctrl: APB register access, job completion,
// timeout, busy-write errors, abort and asynchronous reset mid-job.
module tb_xgcd_job_ctrl;

  logic        CLK;
  logic        RESETn;
  logic [11:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        ENG_START;
  logic [31:0] ENG_A, ENG_B;
  logic        ENG_DONE;
  logic [31:0] ENG_RESULT;
  logic        IRQ, START_OUT, DONE_OUT;

  int checks = 0;
  int errors = 0;
  int startCount = 0;
  int doneOutCount = 0;
  int engLat = 0;
  int engCnt = 0;
  int startBefore;
  logic [31:0] rd;
  logic        err;

  xgcd_job_ctrl #(.WIDTH(32)) dut (
    .CLK(CLK), .RESETn(RESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .ENG_START(ENG_START), .ENG_A(ENG_A), .ENG_B(ENG_B),
    .ENG_DONE(ENG_DONE), .ENG_RESULT(ENG_RESULT), .IRQ(IRQ),
    .START_OUT(START_OUT), .DONE_OUT(DONE_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Engine model: raises ENG_DONE for one cycle so it is sampled on the
  // engLat-th WAIT edge; engLat of 0 means the engine never finishes.
  always @(negedge CLK) begin
    if (ENG_START) begin
      startCount++;
      engCnt = engLat;
      ENG_DONE = 1'b0;
    end else if (engCnt > 0) begin
      engCnt--;
      ENG_DONE = (engCnt == 0);
    end else begin
      ENG_DONE = 1'b0;
    end
    if (DONE_OUT) doneOutCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic apbWrite(input logic [11:0] a, input logic [31:0] d, output logic e);
    @(negedge CLK);
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge CLK);
    PENABLE = 1'b1;
    #1 e = PSLVERR;
    @(negedge CLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apbRead(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(negedge CLK);
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge CLK);
    PENABLE = 1'b1;
    #1 begin d = PRDATA; e = PSLVERR; end
    @(negedge CLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic applyStimulus(input int lat, input logic [31:0] res);
    engLat = lat;
    ENG_RESULT = res;
  endtask

  initial begin
    RESETn = 1'b0; PADDR = '0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = '0;
    ENG_DONE = 1'b0; ENG_RESULT = '0;
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

    checkOutput("rst_prdata", PRDATA, 32'd0);
    checkOutput("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    checkOutput("rst_engstart", {31'd0, ENG_START}, 32'd0);
    checkOutput("rst_enga", ENG_A, 32'd0);
    checkOutput("rst_irq", {31'd0, IRQ}, 32'd0);
    checkOutput("rst_preaddy", {31'd0, PREADY}, 32'd1);

    apbRead(12'h000, rd, err);
    checkOutput("id", rd, 32'h5A5A5A5A);
    checkOutput("id_err", {31'd0, err}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      apbRead(12'(i * 4), rd, err);
      checkOutput($sformatf("rst_reg%0d", i), rd, 32'd0);
      checkOutput($sformatf("rst_err%0d", i), {31'd0, err}, 32'd0);
    end
    apbRead(12'h020, rd, err);
    checkOutput("unmapped_rd", rd, 32'd0);
    checkOutput("unmapped_err", {31'd0, err}, 32'd1);
    apbWrite(12'h000, 32'h1234, err);
    checkOutput("ro_wr_err", {31'd0, err}, 32'd0);
    apbRead(12'h000, rd, err);
    checkOutput("id_after_wr", rd, 32'h5A5A5A5A);

    // Normal job: result 6 after 3 WAIT cycles.
    applyStimulus(3, 32'd6);
    apbWrite(12'h00C, 32'd48, err);
    apbWrite(12'h010, 32'd18, err);
    apbWrite(12'h004, 32'h3, err);
    checkOutput("go_err", {31'd0, err}, 32'd0);
    checkOutput("launch_start", {31'd0, ENG_START}, 32'd1);
    checkOutput("launch_startout", {31'd0, START_OUT}, 32'd1);
    @(negedge CLK);
    checkOutput("wait_start_low", {31'd0, ENG_START}, 32'd0);
    repeat (10) @(negedge CLK);
    checkOutput("job1_starts", 32'(startCount), 32'd1);
    checkOutput("job1_doneouts", 32'(doneOutCount), 32'd1);
    checkOutput("job1_enga", ENG_A, 32'd48);
    checkOutput("job1_engb", ENG_B, 32'd18);
    checkOutput("job1_irq", {31'd0, IRQ}, 32'd1);
    apbRead(12'h014, rd, err);
    checkOutput("job1_result", rd, 32'd6);
    apbRead(12'h018, rd, err);
    checkOutput("job1_cycles", rd, 32'd3);
    apbRead(12'h008, rd, err);
    checkOutput("job1_status", rd, 32'h2);
    apbRead(12'h004, rd, err);
    checkOutput("ctrl_readback", rd, 32'h2);
    apbWrite(12'h008, 32'h2, err);
    @(negedge CLK);
    checkOutput("w1c_irq", {31'd0, IRQ}, 32'd0);
    apbRead(12'h008, rd, err);
    checkOutput("w1c_status", rd, 32'h0);

    // Timeout: engine never answers, TLIMIT=5.
    applyStimulus(0, 32'd99);
    apbWrite(12'h01C, 32'd5, err);
    apbWrite(12'h004, 32'h3, err);
    repeat (12) @(negedge CLK);
    apbRead(12'h008, rd, err);
    checkOutput("to_status", rd, 32'h4);
    apbRead(12'h018, rd, err);
    checkOutput("to_cycles", rd, 32'd5);
    apbRead(12'h014, rd, err);
    checkOutput("to_result", rd, 32'd6);
    checkOutput("to_doneouts", 32'(doneOutCount), 32'd1);
    checkOutput("to_irq", {31'd0, IRQ}, 32'd1);
    apbWrite(12'h008, 32'h4, err);

    // Busy writes rejected, then abort.
    apbWrite(12'h01C, 32'd0, err);
    apbWrite(12'h004, 32'h1, err);
    apbRead(12'h008, rd, err);
    checkOutput("busy_status", rd, 32'h1);
    apbWrite(12'h004, 32'h1, err);
    checkOutput("busy_go_err", {31'd0, err}, 32'd1);
    apbWrite(12'h00C, 32'd7, err);
    checkOutput("busy_opa_err", {31'd0, err}, 32'd1);
    repeat (3) @(negedge CLK);
    checkOutput("busy_starts", 32'(startCount), 32'd3);
    checkOutput("busy_enga", ENG_A, 32'd48);
    apbRead(12'h00C, rd, err);
    checkOutput("busy_opa", rd, 32'd48);
    apbWrite(12'h004, 32'h4, err);
    checkOutput("abort_err", {31'd0, err}, 32'd0);
    checkOutput("abort_idle_start", {31'd0, ENG_START}, 32'd0);
    apbRead(12'h008, rd, err);
    checkOutput("abort_status", rd, 32'h0);
    checkOutput("abort_irq", {31'd0, IRQ}, 32'd0);

    // Done and timeout on the same edge: done wins.
    applyStimulus(4, 32'h55);
    apbWrite(12'h01C, 32'd4, err);
    apbWrite(12'h004, 32'h3, err);
    repeat (10) @(negedge CLK);
    apbRead(12'h008, rd, err);
    checkOutput("tie_status", rd, 32'h2);
    apbRead(12'h014, rd, err);
    checkOutput("tie_result", rd, 32'h55);
    apbRead(12'h018, rd, err);
    checkOutput("tie_cycles", rd, 32'd4);
    apbWrite(12'h008, 32'h6, err);

    // Asynchronous reset in the middle of WAIT.
    applyStimulus(0, 32'd0);
    apbWrite(12'h01C, 32'd0, err);
    apbWrite(12'h004, 32'h3, err);
    startBefore = startCount + 1;
    repeat (3) @(negedge CLK);
    #2 RESETn = 1'b0;
    #1;
    checkOutput("areset_prdata", PRDATA, 32'd0);
    checkOutput("areset_enga", ENG_A, 32'd0);
    checkOutput("areset_engb", ENG_B, 32'd0);
    checkOutput("areset_start", {31'd0, ENG_START}, 32'd0);
    checkOutput("areset_irq", {31'd0, IRQ}, 32'd0);
    checkOutput("areset_doneout", {31'd0, DONE_OUT}, 32'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (4) @(negedge CLK);
    apbRead(12'h008, rd, err);
    checkOutput("areset_status", rd, 32'h0);
    checkOutput("areset_starts", 32'(startCount), 32'(startBefore));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
